pipe_hazard_unit: RTL and testbench

Parametrised hazard-detection and forwarding-control block for the 5-stage pipeline. It tracks the destination register of every in-flight instruction from EX through WB in an internal shift pipeline. It stalls the ID stage on an unresolvable load-use RAW hazard and returns a per-operand forwarding select for the EX operand muxes. It also squashes wrong-path entries on a branch flush and keeps a saturating stall counter for performance monitoring.

---
 rtl/pipe_hazard_unit.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard detection and forwarding control for the 5-stage pipeline.
// The destination register of every instruction in EX..WB is tracked in a
// small shift pipeline of DEPTH entries (stage 1 = EX, youngest). For each
// source operand of the instruction in ID the youngest matching producer is
// found:
//   - a non-load producer, or a load that has reached LOAD_READY_STAGE, is
//     forwarded (fwd_sel = stage index);
//   - a load that is not yet forwardable stalls ID and inserts a bubble.
// A taken branch (flush) kills the ID instruction and the FLUSH_DEPTH
// youngest tracked entries. Stalled cycles are counted in a saturating
// performance counter.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   id_valid     in   ID holds a valid instruction
//   id_wen       in   ID instruction writes a register
//   id_waddr     in   ID destination register
//   id_is_load   in   ID instruction is a load
//   id_src_addr  in   source registers, operand i at [i*REGADDR_WIDTH +: REGADDR_WIDTH]
//   id_src_used  in   operand i is actually read
//   flush        in   branch taken, squash wrong-path instructions
//   stall        out  hold PC and IF/ID, bubble into EX (combinational)
//   fwd_sel      out  per operand: 0 = register file, k = stage k result (combinational)
//   stall_count  out  saturating count of stalled cycles (registered)
// -----------------------------------------------------------------------------
module pipe_hazard_unit #(
    parameter int REGADDR_WIDTH    = 5,
    parameter int NUM_SRC          = 2,
    parameter int DEPTH            = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int FLUSH_DEPTH      = 1,
    parameter int CNT_WIDTH        = 16,
    parameter int SEL_W            = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             id_valid,
    input  logic                             id_wen,
    input  logic [REGADDR_WIDTH-1:0]         id_waddr,
    input  logic                             id_is_load,
    input  logic [NUM_SRC*REGADDR_WIDTH-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]               id_src_used,
    input  logic                             flush,
    output logic                             stall,
    output logic [NUM_SRC*SEL_W-1:0]         fwd_sel,
    output logic [CNT_WIDTH-1:0]             stall_count
);

    // Tracked entries, index k-1 holds stage k.
    logic [DEPTH-1:0]         valid_r;
    logic [DEPTH-1:0]         wen_r;
    logic [DEPTH-1:0]         load_r;
    logic [REGADDR_WIDTH-1:0] waddr_r [DEPTH];
    logic [CNT_WIDTH-1:0]     stall_count_r;

    logic                     hazard_s;
    logic                     stall_s;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_s;

    // Youngest-producer search per operand; derives forwarding selects and
    // the raw load-use hazard.
    always_comb begin
        logic [REGADDR_WIDTH-1:0] src_v;
        logic                     found_v;
        logic                     hit_load_v;
        int                       hit_k_v;

        fwd_sel_s = '0;
        hazard_s  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_v      = id_src_addr[i*REGADDR_WIDTH +: REGADDR_WIDTH];
            found_v    = 1'b0;
            hit_load_v = 1'b0;
            hit_k_v    = 0;
            // Scan oldest to youngest so the youngest match is the last one kept.
            for (int k = DEPTH; k >= 1; k--) begin
                if (id_valid && id_src_used[i] && (src_v != '0) &&
                    valid_r[k-1] && wen_r[k-1] && (waddr_r[k-1] == src_v)) begin
                    found_v    = 1'b1;
                    hit_load_v = load_r[k-1];
                    hit_k_v    = k;
                end else begin
                    found_v    = found_v;
                end
            end
            if (found_v && hit_load_v && (hit_k_v < LOAD_READY_STAGE)) begin
                // Load data not available yet: read nothing, ID must wait.
                hazard_s = 1'b1;
                fwd_sel_s[i*SEL_W +: SEL_W] = '0;
            end else if (found_v) begin
                fwd_sel_s[i*SEL_W +: SEL_W] = SEL_W'(hit_k_v);
            end else begin
                fwd_sel_s[i*SEL_W +: SEL_W] = '0;
            end
        end
        // A taken branch discards the ID instruction, so it never stalls.
        stall_s = hazard_s && !flush;
    end

    // Tracking pipeline advance and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r       <= '0;
            wen_r         <= '0;
            load_r        <= '0;
            stall_count_r <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                waddr_r[k] <= '0;
            end
        end else begin
            // Stage 1 captures ID only when it really issues; r0 is never a producer.
            valid_r[0] <= id_valid && !stall_s && !flush;
            wen_r[0]   <= id_wen && (id_waddr != '0);
            waddr_r[0] <= id_waddr;
            load_r[0]  <= id_is_load;
            for (int k = 1; k < DEPTH; k++) begin
                // Entries entering stages 2..FLUSH_DEPTH+1 are wrong-path on flush.
                valid_r[k] <= valid_r[k-1] && !(flush && (k <= FLUSH_DEPTH));
                wen_r[k]   <= wen_r[k-1];
                waddr_r[k] <= waddr_r[k-1];
                load_r[k]  <= load_r[k-1];
            end
            if (stall_s && (stall_count_r != {CNT_WIDTH{1'b1}})) begin
                stall_count_r <= stall_count_r + CNT_WIDTH'(1);
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign stall       = stall_s;
    assign fwd_sel     = fwd_sel_s;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_unit
//
// Self-checking bench for pipe_hazard_unit. A default-parameter instance and a
// CNT_WIDTH=4 instance share all inputs; the second one exposes counter
// saturation. Each step drives ID/flush inputs after the falling edge, pushes
// the hand-derived expected outputs to a scoreboard queue, then pops and
// compares them before the next rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_unit;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_wen;
    logic [4:0]  id_waddr;
    logic        id_is_load;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_used;
    logic        flush;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [15:0] stall_count;
    logic        stall_s4;
    logic [3:0]  fwd_sel_s4;
    logic [3:0]  stall_count_s4;

    int checks;
    int errors;

    typedef struct {
        string       tag;
        logic        stall;
        logic [1:0]  f0;
        logic [1:0]  f1;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb_q[$];

    pipe_hazard_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wen(id_wen),
        .id_waddr(id_waddr), .id_is_load(id_is_load), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .flush(flush), .stall(stall),
        .fwd_sel(fwd_sel), .stall_count(stall_count)
    );

    pipe_hazard_unit #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wen(id_wen),
        .id_waddr(id_waddr), .id_is_load(id_is_load), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .flush(flush), .stall(stall_s4),
        .fwd_sel(fwd_sel_s4), .stall_count(stall_count_s4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Push expected outputs; cnt4 is the 4-bit counter's saturated view.
    task automatic push_exp(input string tag, input logic es, input int ef0, input int ef1, input int ecnt);
        exp_t e;
        e.tag   = tag;
        e.stall = es;
        e.f0    = 2'(ef0);
        e.f1    = 2'(ef1);
        e.cnt   = 16'(ecnt);
        e.cnt4  = (ecnt > 15) ? 4'd15 : 4'(ecnt);
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val({e.tag, ".stall"}, {31'd0, stall},         {31'd0, e.stall});
            check_val({e.tag, ".f0"},    {30'd0, fwd_sel[1:0]},  {30'd0, e.f0});
            check_val({e.tag, ".f1"},    {30'd0, fwd_sel[3:2]},  {30'd0, e.f1});
            check_val({e.tag, ".cnt"},   {16'd0, stall_count},   {16'd0, e.cnt});
            check_val({e.tag, ".cnt4"},  {28'd0, stall_count_s4}, {28'd0, e.cnt4});
        end
    endtask

    // One cycle: drive after falling edge, record expectation, compare.
    task automatic step(input string tag, input logic v, input logic w, input int wa,
                        input logic ld, input int s0, input int s1, input logic [1:0] used,
                        input logic fl, input logic es, input int ef0, input int ef1, input int ecnt);
        @(negedge clk);
        id_valid    = v;
        id_wen      = w;
        id_waddr    = 5'(wa);
        id_is_load  = ld;
        id_src_addr = {5'(s1), 5'(s0)};
        id_src_used = used;
        flush       = fl;
        push_exp(tag, es, ef0, ef1, ecnt);
        #2;
        pop_check();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        id_valid    = 1'b1;
        id_wen      = 1'b1;
        id_waddr    = 5'd3;
        id_is_load  = 1'b1;
        id_src_addr = {5'd3, 5'd3};
        id_src_used = 2'b11;
        flush       = 1'b0;
        #2;
        push_exp("reset", 1'b0, 0, 0, 0);
        pop_check();
        @(negedge clk);
        rst = 1'b0;

        // ALU dependency: add r3, then readers see stages 1, 2, 3, then retired.
        step("alu_issue", 1, 1, 3, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("alu_ex",    1, 0, 0, 0, 3, 3, 2'b01, 0, 0, 1, 0, 0);
        step("alu_mem",   1, 0, 0, 0, 3, 0, 2'b01, 0, 0, 2, 0, 0);
        step("alu_wb",    1, 0, 0, 0, 3, 0, 2'b01, 0, 0, 3, 0, 0);
        step("alu_gone",  1, 0, 0, 0, 3, 0, 2'b01, 0, 0, 0, 0, 0);

        // Load-use: one stall, then forward from MEM.
        step("lw_issue",  1, 1, 5, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("lu_stall",  1, 0, 0, 0, 0, 5, 2'b10, 0, 1, 0, 0, 0);
        step("lu_fwd",    1, 0, 0, 0, 0, 5, 2'b10, 0, 0, 0, 2, 1);

        // Youngest wins, r0 never forwarded, unused operands ignored.
        step("r4_a",      1, 1, 4, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
        step("r4_b",      1, 1, 4, 0, 4, 0, 2'b01, 0, 0, 1, 0, 1);
        step("young",     1, 1, 0, 0, 4, 0, 2'b01, 0, 0, 1, 0, 1);
        step("r0_src",    1, 0, 0, 0, 0, 4, 2'b11, 0, 0, 0, 2, 1);
        step("unused",    1, 0, 0, 0, 4, 4, 2'b00, 0, 0, 0, 0, 1);

        // Flush kills r7 in stage 1 and the ID instruction writing r8.
        step("r7_issue",  1, 1, 7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
        step("flush",     1, 1, 8, 0, 0, 0, 2'b00, 1, 0, 0, 0, 1);
        step("post_fl",   1, 0, 0, 0, 7, 8, 2'b11, 0, 0, 0, 0, 1);

        // Flush concurrent with load-use: no stall, counter unchanged.
        step("lw6_issue", 1, 1, 6, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1);
        step("fl_lu",     1, 0, 0, 0, 0, 6, 2'b10, 1, 0, 0, 0, 1);
        step("post_fllu", 1, 0, 0, 0, 0, 6, 2'b10, 0, 0, 0, 0, 1);

        // Fill all stages, create a stall, then reset asynchronously.
        step("fill_r1",   1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
        step("fill_r2",   1, 1, 2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
        step("fill_lw9",  1, 1, 9, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1);
        step("pre_rst",   1, 0, 0, 0, 9, 1, 2'b11, 0, 1, 0, 3, 1);
        #1;
        rst = 1'b1;
        #1;
        push_exp("async_rst", 1'b0, 0, 0, 0);
        pop_check();
        @(negedge clk);
        rst = 1'b0;
        step("after_rst", 1, 0, 0, 0, 9, 1, 2'b11, 0, 0, 0, 0, 0);

        // Saturation: 20 load-use stalls; the 4-bit counter sticks at 15.
        for (int i = 0; i < 20; i++) begin
            step("sat_lw",   1, 1, 5, 1, 0, 0, 2'b00, 0, 0, 0, 0, i);
            step("sat_stl",  1, 0, 0, 0, 5, 0, 2'b01, 0, 1, 0, 0, i);
            step("sat_fwd",  1, 0, 0, 0, 5, 0, 2'b01, 0, 0, 2, 0, i + 1);
        end
        step("sat_hold",  0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
